// File: rtl/sll_pipe.sv
// sll_pipe: five-stage pipelined 32-bit logical left barrel shifter with a
// valid/ready handshake. Stage k applies the 2^k component of the shift amount.
module sll_pipe (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in,
    input  logic [4:0]  shift,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out
);
    localparam int STAGES = 5;

    logic [STAGES-1:0] valid_r;
    logic [31:0]       data_r [STAGES];
    logic [3:0]        sh0_r;
    logic [2:0]        sh1_r;
    logic [1:0]        sh2_r;
    logic              sh3_r;

    logic [STAGES-1:0] valid_nx_s;
    logic [31:0]       data_nx_s [STAGES];
    logic [31:0]       in_data_s;
    logic [3:0]        sh0_nx_s;
    logic              advance_s;

    // Global stall: only a valid result the consumer refuses freezes the pipe.
    always_comb begin
        advance_s = !(valid_r[STAGES-1] && !out_ready);
    end

    // Next-stage values; each stage consumes the low bit of its remaining shift.
    always_comb begin
        if (in_valid) begin
            in_data_s = in;
            sh0_nx_s  = shift[4:1];
        end else begin
            in_data_s = 32'h0000_0000;
            sh0_nx_s  = 4'h0;
        end

        valid_nx_s[0] = in_valid;
        valid_nx_s[1] = valid_r[0];
        valid_nx_s[2] = valid_r[1];
        valid_nx_s[3] = valid_r[2];
        valid_nx_s[4] = valid_r[3];

        if (in_valid && shift[0]) begin
            data_nx_s[0] = {in_data_s[30:0], 1'b0};
        end else begin
            data_nx_s[0] = in_data_s;
        end

        if (sh0_r[0]) begin
            data_nx_s[1] = {data_r[0][29:0], 2'b00};
        end else begin
            data_nx_s[1] = data_r[0];
        end

        if (sh1_r[0]) begin
            data_nx_s[2] = {data_r[1][27:0], 4'h0};
        end else begin
            data_nx_s[2] = data_r[1];
        end

        if (sh2_r[0]) begin
            data_nx_s[3] = {data_r[2][23:0], 8'h00};
        end else begin
            data_nx_s[3] = data_r[2];
        end

        if (sh3_r) begin
            data_nx_s[4] = {data_r[3][15:0], 16'h0000};
        end else begin
            data_nx_s[4] = data_r[3];
        end
    end

    // Stage registers: synchronous clear, load-all on advance, otherwise hold.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_r <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                data_r[k] <= 32'h0000_0000;
            end
            sh0_r <= 4'h0;
            sh1_r <= 3'h0;
            sh2_r <= 2'h0;
            sh3_r <= 1'b0;
        end else if (advance_s) begin
            valid_r <= valid_nx_s;
            for (int k = 0; k < STAGES; k++) begin
                data_r[k] <= data_nx_s[k];
            end
            sh0_r <= sh0_nx_s;
            sh1_r <= sh0_r[3:1];
            sh2_r <= sh1_r[2:1];
            sh3_r <= sh2_r[1];
        end else begin
            valid_r <= valid_r;
        end
    end

    assign in_ready  = advance_s;
    assign out_valid = valid_r[STAGES-1];
    assign out       = data_r[STAGES-1];
endmodule

// File: tb/tb_sll_pipe.sv
// Self-checking bench for sll_pipe: directed latency/stall/reset scenarios plus
// a long random run, all results checked in order against a scoreboard queue.
module tb_sll_pipe;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  shift;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];
    logic [31:0] sb_exp;

    always #5 clock = ~clock;

    sll_pipe dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_data),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_data)
    );

    // Scoreboard: sampled mid-cycle, so it sees what the next rising edge will commit.
    always @(negedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got out=%h with no operand outstanding", out_data);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if (out_data !== sb_exp) begin
                        failures++;
                        $display("FAIL sb_data: got out=%h expected %h", out_data, sb_exp);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data << shift);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        shift     = 5'd3;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0000_0000) begin
            failures++;
            $display("FAIL reset_out: got valid=%b out=%h expected 0/00000000", out_valid, out_data);
        end
        reset_n  = 1'b1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        for (int t = 0; t < 7; t++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_no_output: cycle %0d got out_valid=%b expected 0", t, out_valid);
            end
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_in_ready: got %b expected 1", in_ready);
        end
        for (int t = 0; t < 8; t++) begin
            if (t == 0) begin
                in_valid = 1'b1;
                in_data  = 32'h0000_0001;
                shift    = 5'd31;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            checks++;
            if (t == 4) begin
                if (out_valid !== 1'b1 || out_data !== 32'h8000_0000) begin
                    failures++;
                    $display("FAIL single_latency: got valid=%b out=%h expected 1/80000000", out_valid, out_data);
                end
            end else if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL single_only_once: after edge %0d got out_valid=%b expected 0", t + 1, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins  [3] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0001};
        logic [4:0]  shs  [3] = '{5'd4, 5'd0, 5'd1};
        logic [31:0] exps [3] = '{32'hFFFF_FFF0, 32'h1234_5678, 32'h0000_0002};
        out_ready = 1'b1;
        for (int t = 0; t < 9; t++) begin
            if (t < 3) begin
                in_valid = 1'b1;
                in_data  = ins[t];
                shift    = shs[t];
            end else begin
                in_valid = 1'b0;
            end
            tick();
            checks++;
            if (t >= 4 && t <= 6) begin
                if (out_valid !== 1'b1 || out_data !== exps[t-4]) begin
                    failures++;
                    $display("FAIL b2b_result: edge %0d got valid=%b out=%h expected 1/%h", t + 1, out_valid, out_data, exps[t-4]);
                end
            end else if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_idle: edge %0d got out_valid=%b expected 0", t + 1, out_valid);
            end
        end
    endtask

    task automatic test_stall();
        int n;
        int guard;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h0101_0101 * (i + 1);
            shift    = 5'(i * 3);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stall_fill_ready: op %0d got in_ready=%b expected 1", i, in_ready);
            end
            tick();
        end
        in_valid = 1'b1;
        in_data  = 32'hBAD0_BAD0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h0101_0101) begin
                failures++;
                $display("FAIL stall_hold: cycle %0d got ready=%b valid=%b out=%h expected 0/1/01010101",
                         c, in_ready, out_valid, out_data);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        guard = 0;
        while (n < 5 && guard < 20) begin
            if (out_valid) n++;
            tick();
            guard++;
        end
        checks++;
        if (n != 5 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL stall_drain: got %0d results, %0d outstanding; expected 5 and 0", n, exp_q.size());
        end
    endtask

    task automatic test_empty_stall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_00FF;
        shift     = 5'd8;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL empty_in_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        for (int t = 2; t <= 5; t++) begin
            tick();
            checks++;
            if (out_valid !== (t == 5)) begin
                failures++;
                $display("FAIL empty_latency: edge %0d got out_valid=%b", t, out_valid);
            end
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h0000_FF00) begin
                failures++;
                $display("FAIL empty_hold: cycle %0d got valid=%b out=%h expected 1/0000ff00", c, out_valid, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_release: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA5A5_0000 + i;
            shift    = 5'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0000_0000) begin
            failures++;
            $display("FAIL flush_reset: got valid=%b out=%h expected 0/00000000", out_valid, out_data);
        end
        for (int t = 0; t < 10; t++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_no_output: cycle %0d got out_valid=%b expected 0", t, out_valid);
            end
        end
    endtask

    task automatic test_random();
        int guard;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            shift     = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 9) > 2);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL random_drain: got %0d outstanding, out_valid=%b; expected 0/0", exp_q.size(), out_valid);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0000_0000;
        shift     = 5'd0;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_empty_stall();
        test_reset_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sll_pipe.md
SLL_PIPE -- requirements
Module: sll_pipe

Interface
REQ-001 Parameters: none; data width fixed at 32 bits, shift amount fixed at 5 bits.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  in/shift carry a valid operand this cycle.
REQ-005 in_ready  output  1  block accepts an operand this cycle.
REQ-006 in  input  32  operand to shift.
REQ-007 shift  input  5  left-shift amount, unsigned 0..31.
REQ-008 out_valid  output  1  out holds a valid result.
REQ-009 out_ready  input  1  consumer accepts the result this cycle.
REQ-010 out  output  32  result: in logically shifted left by shift, zero-filled.

Function
REQ-011 Shall be a 5-stage pipelined logical left barrel shifter; stage k (k=0..4) shifts left by 2^k when bit k of the operand's shift amount is 1, else passes data unchanged.
REQ-012 Vacated low-order bits shall be filled with 0; bits shifted past bit 31 shall be discarded.
REQ-013 Each stage shall register: valid bit, 32-bit data, and the remaining unused shift bits, so an operand's shift amount travels with it.
REQ-014 out and out_valid shall be driven directly from stage-4 registers (no combinational path from in to out).
REQ-015 advance = !(out_valid && !out_ready); when advance=1 every stage loads from its predecessor and stage 0 loads from the inputs; when advance=0 all stage registers hold.
REQ-016 in_ready shall equal advance; an operand is accepted iff in_valid && in_ready in the same cycle.
REQ-017 When advance=1 and in_valid=0, stage 0 shall load valid=0 (bubble); bubbles propagate like operands.
REQ-018 Latency: an operand accepted in cycle N shall appear with out_valid=1 in cycle N+5 when no stall occurs; each stall cycle adds one cycle.
REQ-019 Throughput: one operand per cycle while out_ready=1 continuously.
REQ-020 While out_valid=1 and out_ready=0, out shall remain stable and no operand shall be lost, duplicated or reordered.
REQ-021 When out_valid=0, advance=1 regardless of out_ready (bubbles never stall the pipe).
REQ-022 Results shall emerge in acceptance order; shift=0 shall pass in unchanged.
REQ-023 in and shift values shall be ignored when in_valid=0 or in_ready=0.

Reset
REQ-024 On a rising clock edge with reset_n=0, all stage valid bits shall clear to 0 and all stage data and shift registers shall clear to 0.
REQ-025 During and after reset: out_valid=0, out=0x0000_0000; in_ready=1 in the first cycle after reset_n returns to 1.
REQ-026 Reset asserted with operands in flight shall discard them; none shall appear at out after reset deasserts.
REQ-027 reset_n shall override in_valid/out_ready in the same cycle; an operand presented while reset_n=0 shall not be accepted.

Verification
REQ-028 in=0x0000_0001, shift=31, out_ready=1, accepted cycle N -> out=0x8000_0000, out_valid=1 in cycle N+5 only.
REQ-029 in=0xFFFF_FFFF shift=4, then 0x1234_5678 shift=0, then 0x8000_0001 shift=1, back-to-back, out_ready=1 -> out=0xFFFF_FFF0, 0x1234_5678, 0x0000_0002 in cycles N+5, N+6, N+7.
REQ-030 Pipe full with five operands, out_ready=0 for 3 cycles -> in_ready=0 and out constant for those 3 cycles; after out_ready=1 all five results emerge in order, none lost.
REQ-031 Pipe empty, out_ready=0, in=0x0000_00FF shift=8 -> in_ready=1, operand accepted, out=0x0000_FF00 out_valid=1 in cycle N+5, then held until out_ready=1.
REQ-032 Three operands in flight, reset_n=0 for one cycle -> out_valid=0, out=0 next cycle, and no result appears in the following 10 cycles with in_valid=0.
REQ-033 Random in/shift/in_valid/out_ready for at least 10000 cycles -> every output equals (in << shift) mod 2^32 of the matching accepted operand, in order.
